// File: rtl/dpram_gen.sv
// Dual-port RAM with per-port read-during-write mode, an optional output
// register, a same-address collision flag and a post-reset clear sweep.
module dpram_gen #(
  parameter int unsigned   AW      = 11,
  parameter int unsigned   DW      = 8,
  parameter int unsigned   WMODE_A = 0,
  parameter int unsigned   WMODE_B = 0,
  parameter int unsigned   OREG    = 0,
  parameter int unsigned   CLR_EN  = 1,
  parameter logic [DW-1:0] INITVAL = '0,
  parameter logic [DW-1:0] SRVAL   = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] AA,
  input  logic [AW-1:0] BA,
  input  logic [DW-1:0] AI,
  input  logic [DW-1:0] BI,
  input  logic          ACS,
  input  logic          BCS,
  input  logic          AWE,
  input  logic          BWE,
  output logic [DW-1:0] AO,
  output logic [DW-1:0] BO,
  output logic          BUSY,
  output logic          COLL
);

  localparam int unsigned   DEPTH     = 1 << AW;
  localparam logic [AW-1:0] CADDR_MAX = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic          busy_q, busy_d;
  logic          clr_we_c;

  logic [DW-1:0] mem_q [DEPTH];

  logic          a_act_c, b_act_c;
  logic          a_wr_c, b_wr_c;
  logic [DW-1:0] a_rd_c, b_rd_c;
  logic [DW-1:0] ao1_q, ao1_d, bo1_q, bo1_d;
  logic          coll_q, coll_d;

  // Clear sweep: walk every address once, then park in IDLE until the next reset
  always_comb begin
    state_d  = state_q;
    caddr_d  = caddr_q;
    clr_we_c = 1'b0;
    if (state_q == CLEAR) begin
      if (CLR_EN == 0) begin
        state_d = IDLE;
      end else begin
        clr_we_c = ~RST;
        if (caddr_q == CADDR_MAX) begin
          state_d = IDLE;
        end else begin
          caddr_d = caddr_q + AW'(1);
        end
      end
    end
    busy_d = (state_d == CLEAR);
  end

  // Clear FSM state, sweep counter and busy flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      caddr_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
      busy_q  <= busy_d;
    end
  end

  // Port qualification; reset also blocks accesses on its first cycle
  always_comb begin
    a_act_c = ACS & ~busy_q & ~RST;
    b_act_c = BCS & ~busy_q & ~RST;
    a_wr_c  = a_act_c & AWE;
    b_wr_c  = b_act_c & BWE;
    a_rd_c  = mem_q[AA];
    b_rd_c  = mem_q[BA];
    coll_d  = a_act_c & b_act_c & (AA == BA) & (AWE | BWE);
  end

  // Storage array; port A is applied last so it wins a same-address write
  always_ff @(posedge CLK) begin
    if (clr_we_c) begin
      mem_q[caddr_q] <= INITVAL;
    end
    if (b_wr_c) begin
      mem_q[BA] <= BI;
    end
    if (a_wr_c) begin
      mem_q[AA] <= AI;
    end
  end

  // Stage-1 read data, selected by each port's read-during-write mode
  always_comb begin
    ao1_d = ao1_q;
    bo1_d = bo1_q;
    if (a_act_c) begin
      if (!AWE) begin
        ao1_d = a_rd_c;
      end else if (WMODE_A == 0) begin
        ao1_d = AI;
      end else if (WMODE_A == 1) begin
        ao1_d = a_rd_c;
      end
    end
    if (b_act_c) begin
      if (!BWE) begin
        bo1_d = b_rd_c;
      end else if (WMODE_B == 0) begin
        bo1_d = BI;
      end else if (WMODE_B == 1) begin
        bo1_d = b_rd_c;
      end
    end
  end

  // Stage-1 output registers and collision flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      ao1_q  <= SRVAL;
      bo1_q  <= SRVAL;
      coll_q <= 1'b0;
    end else begin
      ao1_q  <= ao1_d;
      bo1_q  <= bo1_d;
      coll_q <= coll_d;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic          a_act_q, b_act_q;
    logic [DW-1:0] ao2_q, ao2_d, bo2_q, bo2_d;

    // Second stage loads only behind a cycle in which the port was active
    always_comb begin
      ao2_d = a_act_q ? ao1_q : ao2_q;
      bo2_d = b_act_q ? bo1_q : bo2_q;
    end

    // Output pipeline registers
    always_ff @(posedge CLK) begin
      if (RST) begin
        a_act_q <= 1'b0;
        b_act_q <= 1'b0;
        ao2_q   <= SRVAL;
        bo2_q   <= SRVAL;
      end else begin
        a_act_q <= a_act_c;
        b_act_q <= b_act_c;
        ao2_q   <= ao2_d;
        bo2_q   <= bo2_d;
      end
    end

    assign AO = ao2_q;
    assign BO = bo2_q;
  end else begin : g_noreg
    assign AO = ao1_q;
    assign BO = bo1_q;
  end

  assign BUSY = busy_q;
  assign COLL = coll_q;

endmodule

// File: tb/tb_dpram_gen.sv
// Bench for dpram_gen: three configurations share one stimulus stream; a
// behavioural model pushes expected outputs per cycle, popped after each edge.
module tb_dpram_gen;

  localparam int unsigned ND    = 3;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] aa, ba;
  logic [7:0] ai, bi;
  logic       acs, bcs, awe, bwe;

  logic [7:0] ao   [ND];
  logic [7:0] bo   [ND];
  logic       coll [ND];
  logic       busy [ND];

  int n_checks = 0;
  int n_errors = 0;

  // dut0: WF/RF, no output reg; dut1: RF/NC with output reg; dut2: no clear sweep
  dpram_gen #(.AW(4), .DW(8), .WMODE_A(0), .WMODE_B(1), .OREG(0), .CLR_EN(1),
              .INITVAL(8'hA5), .SRVAL(8'h3C)) u_dut0 (
    .CLK(clk), .RST(rst), .AA(aa), .BA(ba), .AI(ai), .BI(bi),
    .ACS(acs), .BCS(bcs), .AWE(awe), .BWE(bwe),
    .AO(ao[0]), .BO(bo[0]), .BUSY(busy[0]), .COLL(coll[0]));

  dpram_gen #(.AW(4), .DW(8), .WMODE_A(1), .WMODE_B(2), .OREG(1), .CLR_EN(1),
              .INITVAL(8'hA5), .SRVAL(8'h00)) u_dut1 (
    .CLK(clk), .RST(rst), .AA(aa), .BA(ba), .AI(ai), .BI(bi),
    .ACS(acs), .BCS(bcs), .AWE(awe), .BWE(bwe),
    .AO(ao[1]), .BO(bo[1]), .BUSY(busy[1]), .COLL(coll[1]));

  dpram_gen #(.AW(4), .DW(8), .WMODE_A(0), .WMODE_B(0), .OREG(0), .CLR_EN(0),
              .INITVAL(8'hA5), .SRVAL(8'h00)) u_dut2 (
    .CLK(clk), .RST(rst), .AA(aa), .BA(ba), .AI(ai), .BI(bi),
    .ACS(acs), .BCS(bcs), .AWE(awe), .BWE(bwe),
    .AO(ao[2]), .BO(bo[2]), .BUSY(busy[2]), .COLL(coll[2]));

  always #5 clk = ~clk;

  // Model configuration, one entry per instance
  int         m_wma  [ND] = '{0, 1, 0};
  int         m_wmb  [ND] = '{1, 2, 0};
  int         m_oreg [ND] = '{0, 1, 0};
  int         m_clr  [ND] = '{1, 1, 0};
  logic [7:0] m_srv  [ND] = '{8'h3C, 8'h00, 8'h00};

  // Model state
  logic [7:0] mm [ND][DEPTH];
  logic [7:0] m_ao1 [ND], m_ao2 [ND], m_bo1 [ND], m_bo2 [ND];
  logic       m_aact [ND], m_bact [ND], m_coll [ND], m_busy [ND];
  logic [3:0] m_caddr [ND];

  typedef struct packed {
    logic [7:0] ao;
    logic [7:0] bo;
    logic       coll;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_a(input logic cs, input logic we, input logic [3:0] a, input logic [7:0] d);
    acs = cs; awe = we; aa = a; ai = d;
  endtask

  task automatic set_b(input logic cs, input logic we, input logic [3:0] a, input logic [7:0] d);
    bcs = cs; bwe = we; ba = a; bi = d;
  endtask

  // Advance the model by one edge using the current inputs and queue its outputs
  task automatic model_step();
    for (int d = 0; d < int'(ND); d++) begin
      logic       a_act, b_act;
      logic [7:0] ra, rb, na, nb;
      exp_t       e;
      a_act = acs && !m_busy[d] && !rst;
      b_act = bcs && !m_busy[d] && !rst;
      ra = mm[d][aa];
      rb = mm[d][ba];
      na = m_ao1[d];
      nb = m_bo1[d];
      if (a_act) begin
        if (!awe)              na = ra;
        else if (m_wma[d] == 0) na = ai;
        else if (m_wma[d] == 1) na = ra;
      end
      if (b_act) begin
        if (!bwe)              nb = rb;
        else if (m_wmb[d] == 0) nb = bi;
        else if (m_wmb[d] == 1) nb = rb;
      end
      if (rst) begin
        m_ao1[d] = m_srv[d]; m_ao2[d] = m_srv[d];
        m_bo1[d] = m_srv[d]; m_bo2[d] = m_srv[d];
        m_aact[d] = 1'b0; m_bact[d] = 1'b0;
        m_coll[d] = 1'b0; m_busy[d] = 1'b1; m_caddr[d] = 4'd0;
      end else begin
        if (m_aact[d]) m_ao2[d] = m_ao1[d];
        if (m_bact[d]) m_bo2[d] = m_bo1[d];
        m_ao1[d] = na;
        m_bo1[d] = nb;
        m_aact[d] = a_act;
        m_bact[d] = b_act;
        m_coll[d] = a_act && b_act && (aa == ba) && (awe || bwe);
        if (m_busy[d]) begin
          if (m_clr[d] == 0) begin
            m_busy[d] = 1'b0;
          end else begin
            mm[d][m_caddr[d]] = 8'hA5;
            if (m_caddr[d] == 4'hF) m_busy[d] = 1'b0;
            else m_caddr[d] = m_caddr[d] + 4'd1;
          end
        end else begin
          if (b_act && bwe) mm[d][ba] = bi;
          if (a_act && awe) mm[d][aa] = ai;
        end
      end
      e.ao   = (m_oreg[d] != 0) ? m_ao2[d] : m_ao1[d];
      e.bo   = (m_oreg[d] != 0) ? m_bo2[d] : m_bo1[d];
      e.coll = m_coll[d];
      e.busy = m_busy[d];
      sb_q.push_back(e);
    end
  endtask

  // One clock: predict, clock, then compare every instance against the queue
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < int'(ND); d++) begin
      exp_t e;
      e = sb_q.pop_front();
      chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(e.busy));
      chk($sformatf("d%0d_coll", d), 32'(coll[d]), 32'(e.coll));
      if (d != 2) begin
        chk($sformatf("d%0d_ao", d), 32'(ao[d]), 32'(e.ao));
        chk($sformatf("d%0d_bo", d), 32'(bo[d]), 32'(e.bo));
      end
    end
  endtask

  initial begin
    int cnt;
    for (int d = 0; d < int'(ND); d++) begin
      m_busy[d] = 1'b1; m_aact[d] = 1'b0; m_bact[d] = 1'b0;
      m_caddr[d] = 4'd0; m_coll[d] = 1'b0;
      m_ao1[d] = 8'h00; m_ao2[d] = 8'h00; m_bo1[d] = 8'h00; m_bo2[d] = 8'h00;
      for (int k = 0; k < int'(DEPTH); k++) mm[d][k] = 8'hxx;
    end
    rst = 1'b1;
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) step();
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_ao_srval", 32'(ao[0]), 32'h3C);
    chk("rst_coll", 32'(coll[0]), 32'd0);

    // Sweep with writes presented that must be ignored
    rst = 1'b0;
    set_a(1'b1, 1'b1, 4'd0, 8'hFF);
    set_b(1'b1, 1'b1, 4'd1, 8'hFF);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy[0]) cnt++;
      step();
      if (i == 0) chk("noclr_busy_low", 32'(busy[2]), 32'd0);
    end
    chk("sweep_len", 32'(cnt), 32'd16);
    chk("sweep_done", 32'(busy[0]), 32'd0);
    chk("busy_ao_srval", 32'(ao[0]), 32'h3C);

    // Read back every address
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 4'(i), 8'h00);
      set_b(1'b1, 1'b0, 4'(15 - i), 8'h00);
      step();
      chk("sweep_val", 32'(ao[0]), 32'hA5);
    end

    // Write-first vs read-first behaviour
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    set_a(1'b1, 1'b1, 4'd3, 8'h12);
    step();
    chk("wf_ao", 32'(ao[0]), 32'h12);
    set_a(1'b1, 1'b1, 4'd3, 8'h34);
    step();
    chk("wf_ao_2", 32'(ao[0]), 32'h34);
    set_a(1'b1, 1'b0, 4'd3, 8'h00);
    step();
    chk("rf_old_data", 32'(ao[1]), 32'h12);
    chk("rd3_new", 32'(ao[0]), 32'h34);
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("rf_rd3_new", 32'(ao[1]), 32'h34);

    // Same-address double write
    set_a(1'b1, 1'b1, 4'd5, 8'h11);
    set_b(1'b1, 1'b1, 4'd5, 8'h22);
    step();
    chk("coll_set", 32'(coll[0]), 32'd1);
    chk("coll_ao_wf", 32'(ao[0]), 32'h11);
    chk("coll_bo_rf", 32'(bo[0]), 32'hA5);
    set_a(1'b1, 1'b0, 4'd5, 8'h00);
    set_b(1'b1, 1'b0, 4'd5, 8'h00);
    step();
    chk("coll_clear", 32'(coll[0]), 32'd0);
    chk("a_wins_a", 32'(ao[0]), 32'h11);
    chk("a_wins_b", 32'(bo[0]), 32'h11);

    // Write on A, read on B, same address
    set_a(1'b1, 1'b1, 4'd6, 8'h77);
    set_b(1'b1, 1'b0, 4'd6, 8'h00);
    step();
    chk("rw_old_data", 32'(bo[0]), 32'hA5);
    chk("rw_coll", 32'(coll[0]), 32'd1);

    // Output-register latency and hold
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    set_a(1'b1, 1'b1, 4'd2, 8'h7E);
    step();
    set_a(1'b1, 1'b0, 4'd2, 8'h00);
    step();
    chk("oreg_not_early", 32'(ao[1]), 32'hA5);
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("oreg_lat", 32'(ao[1]), 32'h7E);
    step();
    chk("oreg_hold", 32'(ao[1]), 32'h7E);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom));
      step();
    end

    // Reset in the middle of a sweep restarts it
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy[0]) cnt++;
      step();
    end
    chk("resweep_len", 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 4'(i), 8'h00);
      set_b(1'b1, 1'b0, 4'(i), 8'h00);
      step();
      chk("resweep_val", 32'(ao[0]), 32'hA5);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
